// File: rtl/cfg_scan_loader.sv
// Configuration scan-chain loader: takes words over valid/ready and shifts them MSB-first into the chain.
// Build macro CFG_SCAN_CRC_EN adds CRC-8 signatures of the bits shifted in and out (crc, crc_match).
//
// state   | meaning
// S_IDLE  | waiting for start
// S_LOAD  | data_ready high, waiting for the next word
// S_SHIFT | shifting the buffered word into the chain, scan_en high
// S_DONE  | CHAIN_LEN bits shifted, done high until the next start
module cfg_scan_loader #(
  parameter int CHAIN_LEN  = 32,
  parameter int WORD_WIDTH = 8,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  chain_scan_in,
  output logic                  chain_scan_en,
  input  logic                  chain_scan_out,
  output logic                  busy,
  output logic                  done
`ifdef CFG_SCAN_CRC_EN
  ,
  output logic [7:0]            crc,
  output logic                  crc_match
`endif
);

  localparam int WC_W = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_rem_bits;
  logic [WC_W-1:0]       r_wrem;
  logic [WC_W-1:0]       w_word_len;
  logic [WORD_WIDTH-1:0] r_buf;
  logic                  r_ready;
  logic                  r_scan_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_ready_nxt;
  logic                  w_scan_en_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_accept;
  logic                  w_start_ok;
  logic                  w_last_bit;

  assign w_accept   = r_ready & data_valid;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last_bit = (r_state == S_SHIFT) & (r_wrem == WC_W'(1));
  assign w_rem_bits = CNT_W'(CHAIN_LEN) - r_cnt;

  // Bits to shift from the word being accepted: a full word, or only what the chain still needs.
  always_comb begin
    w_word_len = WC_W'(WORD_WIDTH);
    if (32'(w_rem_bits) < 32'(WORD_WIDTH)) begin
      w_word_len = WC_W'(w_rem_bits);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_scan_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= w_ready_nxt;
      r_scan_en <= w_scan_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = (r_cnt == CNT_W'(CHAIN_LEN - 1)) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  if (start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_ready_nxt   = (w_state_nxt == S_LOAD);
    w_scan_en_nxt = (w_state_nxt == S_SHIFT);
    w_busy_nxt    = (w_state_nxt == S_LOAD) | (w_state_nxt == S_SHIFT);
    w_done_nxt    = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wrem <= '0;
      r_buf  <= '0;
    end else begin
      if (w_start_ok) begin
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_accept) begin
        r_buf  <= data_in;
        r_wrem <= w_word_len;
      end else if (r_state == S_SHIFT) begin
        r_buf  <= r_buf << 1;
        r_wrem <= r_wrem - WC_W'(1);
      end
    end
  end

  assign data_ready    = r_ready;
  assign chain_scan_en = r_scan_en;
  assign chain_scan_in = r_buf[WORD_WIDTH-1];
  assign busy          = r_busy;
  assign done          = r_done;

`ifdef CFG_SCAN_CRC_EN
  logic [7:0] r_crc;
  logic [7:0] r_crc_old;
  logic [7:0] w_crc_nxt;
  logic [7:0] w_crc_old_nxt;
  logic       r_crc_match;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // Chain emits its old content in the same order new bits enter, so equal CRCs mean an identical reload.
  always_comb begin
    w_crc_nxt     = r_crc;
    w_crc_old_nxt = r_crc_old;
    if (w_start_ok) begin
      w_crc_nxt     = 8'h00;
      w_crc_old_nxt = 8'h00;
    end else if (r_state == S_SHIFT) begin
      w_crc_nxt     = crc8_step(r_crc, chain_scan_in);
      w_crc_old_nxt = crc8_step(r_crc_old, chain_scan_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc       <= 8'h00;
      r_crc_old   <= 8'h00;
      r_crc_match <= 1'b0;
    end else begin
      r_crc       <= w_crc_nxt;
      r_crc_old   <= w_crc_old_nxt;
      r_crc_match <= (w_state_nxt == S_DONE) & (w_crc_nxt == w_crc_old_nxt);
    end
  end

  assign crc       = r_crc;
  assign crc_match = r_crc_match;
`else
  logic w_unused_scan_out;
  assign w_unused_scan_out = chain_scan_out;
`endif

endmodule
